// File: rtl/reset_sequencer.sv
// Staged reset release: PHY first, then datapath core, then CPU, each after a
// programmable wait. Any new trigger restarts the whole sequence from HOLD.
module reset_sequencer #(
    parameter int HOLD_CYCLES      = 16,
    parameter int PHY_WAIT_CYCLES  = 1000,
    parameter int CORE_WAIT_CYCLES = 100
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       watchdog_rst_i,
    input  logic       sw_rst_req_i,
    input  logic       cause_clr_i,
    output logic       phy_rst_o,
    output logic       core_rst_o,
    output logic       cpu_rst_o,
    output logic       rst_busy_o,
    output logic [1:0] rst_cause_o,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_PHY_WAIT  = 2'd1,
        ST_CORE_WAIT = 2'd2,
        ST_IDLE      = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SYS  = 2'b01;
    localparam logic [1:0] CAUSE_WD   = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    // Counters load N-1 so that a stage lasts exactly N cycles including the load cycle.
    localparam logic [23:0] C_HOLD_LOAD = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] C_PHY_LOAD  = 24'(PHY_WAIT_CYCLES - 1);
    localparam logic [23:0] C_CORE_LOAD = 24'(CORE_WAIT_CYCLES - 1);

    state_t      r_state;
    logic [23:0] r_cnt;
    logic        r_wd_last;
    logic        r_phy_rst;
    logic        r_core_rst;
    logic        r_cpu_rst;
    logic        r_busy;
    logic [1:0]  r_cause;

    logic w_wd_edge;
    logic w_soft_trigger;

    assign w_wd_edge      = watchdog_rst_i & ~r_wd_last;
    assign w_soft_trigger = w_wd_edge | sw_rst_req_i;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            // wd_last=1 keeps a watchdog level held through reset from retriggering.
            r_state    <= ST_HOLD;
            r_cnt      <= C_HOLD_LOAD;
            r_wd_last  <= 1'b1;
            r_phy_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b1;
            r_cause    <= CAUSE_SYS;
        end else begin
            r_wd_last <= watchdog_rst_i;
            if (w_soft_trigger) begin
                r_state    <= ST_HOLD;
                r_cnt      <= C_HOLD_LOAD;
                r_phy_rst  <= 1'b1;
                r_core_rst <= 1'b1;
                r_cpu_rst  <= 1'b1;
                r_busy     <= 1'b1;
                r_cause    <= w_wd_edge ? CAUSE_WD : CAUSE_SW;
            end else begin
                if (cause_clr_i) begin
                    r_cause <= CAUSE_NONE;
                end
                case (r_state)
                    ST_HOLD: begin
                        if (r_cnt != 24'd0) begin
                            r_cnt <= r_cnt - 24'd1;
                        end else begin
                            r_state   <= ST_PHY_WAIT;
                            r_cnt     <= C_PHY_LOAD;
                            r_phy_rst <= 1'b0;
                        end
                    end
                    ST_PHY_WAIT: begin
                        if (r_cnt != 24'd0) begin
                            r_cnt <= r_cnt - 24'd1;
                        end else begin
                            r_state    <= ST_CORE_WAIT;
                            r_cnt      <= C_CORE_LOAD;
                            r_core_rst <= 1'b0;
                        end
                    end
                    ST_CORE_WAIT: begin
                        if (r_cnt != 24'd0) begin
                            r_cnt <= r_cnt - 24'd1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= 24'd0;
                            r_cpu_rst <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_cnt <= 24'd0;
                    end
                endcase
            end
        end
    end

    assign phy_rst_o   = r_phy_rst;
    assign core_rst_o  = r_core_rst;
    assign cpu_rst_o   = r_cpu_rst;
    assign rst_busy_o  = r_busy;
    assign rst_cause_o = r_cause;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD=4, PHY_WAIT=3, CORE_WAIT=2:
// phy falls 4 cycles after the last trigger, core after 7, cpu/busy after 9.
module tb_reset_sequencer;

    logic       clk;
    logic       sys_rst;
    logic       wd_rst;
    logic       sw_req;
    logic       cause_clr;
    logic       phy_rst;
    logic       core_rst;
    logic       cpu_rst;
    logic       busy;
    logic [1:0] cause;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .HOLD_CYCLES     (4),
        .PHY_WAIT_CYCLES (3),
        .CORE_WAIT_CYCLES(2)
    ) dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (sys_rst),
        .watchdog_rst_i(wd_rst),
        .sw_rst_req_i  (sw_req),
        .cause_clr_i   (cause_clr),
        .phy_rst_o     (phy_rst),
        .core_rst_o    (core_rst),
        .cpu_rst_o     (cpu_rst),
        .rst_busy_o    (busy),
        .rst_cause_o   (cause),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1ns after it, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- sequence checker ----------------
    // Call right after the trigger edge (k=0); walks 11 samples through IDLE.
    task automatic check_seq(input string name, input logic [1:0] exp_cause);
        logic       e_phy, e_core, e_cpu;
        logic [1:0] e_state;
        for (int k = 0; k <= 10; k++) begin
            e_phy   = (k < 4);
            e_core  = (k < 7);
            e_cpu   = (k < 9);
            e_state = (k < 4) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
            checks++;
            if (phy_rst !== e_phy || core_rst !== e_core || cpu_rst !== e_cpu ||
                busy !== e_cpu || dbg_state !== e_state) begin
                errors++;
                $display("FAIL %s k=%0d got phy/core/cpu/busy/state=%b%b%b%b/%0d exp %b%b%b%b/%0d",
                         name, k, phy_rst, core_rst, cpu_rst, busy, dbg_state,
                         e_phy, e_core, e_cpu, e_cpu, e_state);
            end
            checks++;
            if (cause !== exp_cause) begin
                errors++;
                $display("FAIL %s_cause k=%0d got %b exp %b", name, k, cause, exp_cause);
            end
            if (k < 10) step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({phy_rst, core_rst, cpu_rst, busy} !== 4'b1111 || cause !== 2'b01 ||
                dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got outs=%b%b%b%b cause=%b state=%0d exp 1111 01 0",
                         i, phy_rst, core_rst, cpu_rst, busy, cause, dbg_state);
            end
        end
        // Last reset edge is the trigger edge; sample k=0 is the current one.
        sys_rst = 1'b0;
        check_seq("power_on", 2'b01);
    endtask

    task automatic test_watchdog_level();
        wd_rst = 1'b1;
        step();
        check_seq("watchdog", 2'b10);
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || phy_rst !== 1'b0) begin
                errors++;
                $display("FAIL wd_no_retrigger cyc=%0d got busy=%b phy=%b exp 0 0", i, busy, phy_rst);
            end
        end
        wd_rst = 1'b0;
        step();
    endtask

    task automatic test_sw_in_core_wait();
        wd_rst = 1'b1;
        step();
        wd_rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (dbg_state !== 2'd2 || {phy_rst, core_rst, cpu_rst} !== 3'b001 || cause !== 2'b10) begin
            errors++;
            $display("FAIL core_wait_reach got state=%0d outs=%b%b%b cause=%b exp 2 001 10",
                     dbg_state, phy_rst, core_rst, cpu_rst, cause);
        end
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        check_seq("sw_restart", 2'b11);
    endtask

    task automatic test_sw_and_wd_same_cycle();
        sw_req = 1'b1;
        wd_rst = 1'b1;
        step();
        sw_req = 1'b0;
        check_seq("sw_wd_prio", 2'b10);
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_wd_single got busy=%b exp 0", busy);
        end
        wd_rst = 1'b0;
        step();
    endtask

    task automatic test_cause_clear();
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        checks++;
        if (cause !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cause_clr_idle got cause=%b busy=%b exp 00 0", cause, busy);
        end
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        step();
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        check_seq("clr_with_sw", 2'b11);
    endtask

    task automatic test_sys_mid_phy_wait();
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (dbg_state !== 2'd1 || {phy_rst, core_rst, cpu_rst} !== 3'b011) begin
            errors++;
            $display("FAIL phy_wait_reach got state=%0d outs=%b%b%b exp 1 011",
                     dbg_state, phy_rst, core_rst, cpu_rst);
        end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check_seq("sys_mid_phy", 2'b01);
    endtask

    // ---------------- main ----------------
    initial begin
        sys_rst   = 1'b1;
        wd_rst    = 1'b0;
        sw_req    = 1'b0;
        cause_clr = 1'b0;
        test_reset();
        step();
        test_watchdog_level();
        test_sw_in_core_wait();
        step();
        test_sw_and_wd_same_cycle();
        test_cause_clear();
        step();
        test_sys_mid_phy_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
